ascon_controller: RTL and testbench
===================================

// Module: ascon_controller
// PURPOSE
//  Control FSM for Ascon-128 AEAD encryption; sits directly upstream of the permutation datapath.
//  Sequences one permutation round per cycle: p^12 init, p^6 per AD/PT block, p^12 final.
//  Drives all datapath enables and round index; valid/ready handshake for 64-bit data blocks.
//  Padding, nonce/key/IV state assembly and the data bus are handled outside this block.
// PARAMETERS
//  G_ROUNDS_A   12  rounds for init/finalization; first round index = 12-G_ROUNDS_A
//  G_ROUNDS_B   6   rounds per AD/PT block; first round index = 12-G_ROUNDS_B
//  G_BLK_W      4   width of block-count inputs
// PORTS
//  clock                 in   1        clock
//  reset_n               in   1        async reset, active low
//  i_start               in   1        start pulse, sampled only in IDLE
//  i_abort               in   1        synchronous abort, any state
//  i_ad_blocks           in   G_BLK_W  number of padded AD blocks (0 = none)
//  i_pt_blocks           in   G_BLK_W  number of padded PT blocks (0 treated as 1)
//  i_data_valid          in   1        upstream data block valid
//  o_data_ready          out  1        block consumed this cycle when ready&&valid
//  o_sys_enable          out  1        datapath enable; 0 = datapath soft reset
//  o_mux_select          out  1        0 = load external state, 1 = feedback
//  o_enable_xor_key_begin  out 1       key XOR into x1,x2 before round
//  o_enable_xor_data_begin out 1       data XOR into x0 before round
//  o_enable_xor_key_end  out  1        key XOR into x3,x4 after round
//  o_enable_xor_lsb_end  out  1        domain-separation bit after round
//  o_enable_cipher_reg   out  1        capture ciphertext block
//  o_enable_tag_reg      out  1        capture tag
//  o_enable_state_reg    out  1        high only in cycles where a round executes
//  o_round               out  4        round index for addition layer
//  o_cipher_valid        out  1        1-cycle pulse, cipher register holds new block
//  o_tag_valid           out  1        level, tag register valid
//  o_busy                out  1        high in INIT/AD/PT/FINAL/ABORT
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0.
//  States: IDLE, INIT, AD, PT, FINAL, ABORT.
//   - Transitions: IDLE->INIT on i_start. INIT->AD if i_ad_blocks!=0, else PT if pt>1, else FINAL.
//   - AD->PT or FINAL after the last AD block. PT->FINAL after PT block P-1. FINAL->IDLE.
//  Round counter: loads start index at phase entry; +1 per executed round; phase ends at index 11.
//  INIT: cycle after i_start, round 0, mux_select=0, external state must be valid.
//   - Every other round has mux_select=1.
//   - Last INIT round: xor_key_end; also xor_lsb_end if i_ad_blocks==0.
//  AD/PT/FINAL first round of each block needs handshake.
//   - o_data_ready=1 combinationally; if i_data_valid=0, stall.
//   - During a stall: state/cipher/tag enables 0, round and counters hold, no limit on stall length.
//   - On the handshake cycle: xor_data_begin=1; PT also cipher_reg=1.
//  AD: last round of last AD block asserts xor_lsb_end.
//  FINAL: absorbs the last PT block.
//   - First cycle: xor_data_begin, xor_key_begin, cipher_reg.
//   - Round index runs 12-G_ROUNDS_A..11.
//   - Last round: xor_key_end + tag_reg.
//  o_cipher_valid: registered pulse in the cycle after cipher_reg=1.
//  o_tag_valid: set at the edge capturing the tag; cleared on next accepted i_start, abort or reset.
//  o_sys_enable: 0 after reset until first i_start; 1 from INIT onward.
//   - Stays 1 in IDLE after completion so cipher/tag remain readable.
//  Abort: i_abort in any non-IDLE state -> ABORT for exactly 1 cycle (sys_enable=0, all enables 0) -> IDLE.
//   - Abort has priority over every other event; abort in IDLE is ignored.
//  i_start while busy is ignored. i_ad_blocks/i_pt_blocks are sampled only at accepted start.
//  Unstalled latency, start-accept to tag capture: 2*G_ROUNDS_A + G_ROUNDS_B*(A+P-1) cycles.
//  o_data_ready is 0 outside handshake cycles; never asserted in IDLE/INIT/ABORT.
// STRUCTURE
//  ascon_pkg:
//   - t_ctrl_state enum.
//   - C_ROUNDS_A=12, C_ROUNDS_B=6, C_LAST_ROUND=4'd11.
//  Single module: FSM, round counter, AD/PT block down-counters, cipher/tag flag registers.
//  Control outputs are combinational from state/counters.
//  No sub-modules; instantiated beside permutation in the ascon top level.
// TESTING
//  A=0,P=1, valid tied high -> 24 round cycles.
//   - Cycle1 mux=0; cycle12 key_end+lsb_end.
//   - Cycle13 data+key_begin+cipher; cycle24 key_end+tag_reg; tag equals golden model.
//  A=2,P=3, valid high -> 48 round cycles; 5 handshakes.
//   - lsb_end only on round 11 of the 2nd AD block.
//   - cipher_valid pulses 3 times; tag/cipher equal golden model.
//  A=1,P=2, valid low 3 cycles at the PT block start -> state_reg=0 for exactly those 3 cycles.
//   - round holds at 6; total 39 cycles; results unchanged.
//  Abort at INIT round 5 -> next cycle sys_enable=0, busy=1.
//   - Following cycle IDLE, busy=0, tag_valid=0; a new start completes correctly.
//  i_start pulsed during AD -> ignored; i_pt_blocks=0 -> identical to P=1 run.
//  reset_n low mid-FINAL -> all outputs 0 immediately; post-reset run matches golden model.

Source files
------------

// File: rtl/ascon_pkg.sv
// Shared types and constants for the Ascon-128 AEAD control logic.
package ascon_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_AD    = 3'd2,
    S_PT    = 3'd3,
    S_FINAL = 3'd4,
    S_ABORT = 3'd5
  } t_ctrl_state;

  localparam int unsigned C_ROUNDS_A   = 12;
  localparam int unsigned C_ROUNDS_B   = 6;
  localparam logic [3:0]  C_LAST_ROUND = 4'd11;

  // Round index of the first round of a phase running 'rounds' rounds;
  // every phase ends on index 11.
  function automatic logic [3:0] first_round(input int unsigned rounds);
    return 4'(32'd12 - rounds);
  endfunction

endpackage

// File: rtl/ascon_controller.sv
// Ascon-128 encryption sequencer: one permutation round per cycle,
// p^a initialisation, p^b per AD/PT block, p^a finalisation.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for i_start; cipher/tag stay readable
// INIT   | p^a over the externally loaded state, key XOR after last round
// AD     | p^b per associated-data block, handshake on each block's first round
// PT     | p^b per plaintext block except the last, ciphertext captured
// FINAL  | absorbs last PT block, p^a, key XOR and tag capture
// ABORT  | one cycle datapath soft reset, then IDLE
module ascon_controller
  import ascon_pkg::*;
#(
  parameter int unsigned G_ROUNDS_A = C_ROUNDS_A,
  parameter int unsigned G_ROUNDS_B = C_ROUNDS_B,
  parameter int unsigned G_BLK_W    = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic [G_BLK_W-1:0] i_ad_blocks,
  input  logic [G_BLK_W-1:0] i_pt_blocks,
  input  logic               i_data_valid,
  output logic               o_data_ready,
  output logic               o_sys_enable,
  output logic               o_mux_select,
  output logic               o_enable_xor_key_begin,
  output logic               o_enable_xor_data_begin,
  output logic               o_enable_xor_key_end,
  output logic               o_enable_xor_lsb_end,
  output logic               o_enable_cipher_reg,
  output logic               o_enable_tag_reg,
  output logic               o_enable_state_reg,
  output logic [3:0]         o_round,
  output logic               o_cipher_valid,
  output logic               o_tag_valid,
  output logic               o_busy
);

  localparam logic [3:0]         L_START_A = first_round(G_ROUNDS_A);
  localparam logic [3:0]         L_START_B = first_round(G_ROUNDS_B);
  localparam logic [G_BLK_W-1:0] L_ONE     = 1;

  t_ctrl_state        state_q, state_d;
  logic [3:0]         round_q, round_d;
  logic [G_BLK_W-1:0] ad_cnt_q, ad_cnt_d;
  logic [G_BLK_W-1:0] pt_cnt_q, pt_cnt_d;
  logic               sys_en_q, sys_en_d;
  logic               cipher_valid_q, cipher_valid_d;
  logic               tag_valid_q, tag_valid_d;
  logic               last_round;
  logic               abort_hit;

  assign last_round = (round_q == C_LAST_ROUND);
  assign abort_hit  = i_abort && (state_q inside {S_INIT, S_AD, S_PT, S_FINAL});

  assign o_round        = round_q;
  assign o_busy         = (state_q != S_IDLE);
  assign o_sys_enable   = sys_en_q;
  assign o_cipher_valid = cipher_valid_q;
  assign o_tag_valid    = tag_valid_q;

  // State, round index, remaining-block counters and status flags.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      round_q        <= 4'd0;
      ad_cnt_q       <= '0;
      pt_cnt_q       <= '0;
      sys_en_q       <= 1'b0;
      cipher_valid_q <= 1'b0;
      tag_valid_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      round_q        <= round_d;
      ad_cnt_q       <= ad_cnt_d;
      pt_cnt_q       <= pt_cnt_d;
      sys_en_q       <= sys_en_d;
      cipher_valid_q <= cipher_valid_d;
      tag_valid_q    <= tag_valid_d;
    end
  end

  // Next-state logic and datapath control decoded from state and round index.
  always_comb begin
    state_d     = state_q;
    round_d     = round_q;
    ad_cnt_d    = ad_cnt_q;
    pt_cnt_d    = pt_cnt_q;
    sys_en_d    = sys_en_q;
    tag_valid_d = tag_valid_q;

    o_data_ready            = 1'b0;
    o_mux_select            = 1'b0;
    o_enable_xor_key_begin  = 1'b0;
    o_enable_xor_data_begin = 1'b0;
    o_enable_xor_key_end    = 1'b0;
    o_enable_xor_lsb_end    = 1'b0;
    o_enable_cipher_reg     = 1'b0;
    o_enable_tag_reg        = 1'b0;
    o_enable_state_reg      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d     = S_INIT;
          round_d     = L_START_A;
          ad_cnt_d    = i_ad_blocks;
          // The last plaintext block is absorbed by FINAL, so PT runs P-1 blocks.
          pt_cnt_d    = (i_pt_blocks == '0) ? '0 : i_pt_blocks - L_ONE;
          sys_en_d    = 1'b1;
          tag_valid_d = 1'b0;
        end
      end

      S_INIT: begin
        o_enable_state_reg = 1'b1;
        o_mux_select       = (round_q != L_START_A);
        round_d            = round_q + 4'd1;
        if (last_round) begin
          o_enable_xor_key_end = 1'b1;
          o_enable_xor_lsb_end = (ad_cnt_q == '0);
          if (ad_cnt_q != '0) begin
            state_d = S_AD;
            round_d = L_START_B;
          end else if (pt_cnt_q != '0) begin
            state_d = S_PT;
            round_d = L_START_B;
          end else begin
            state_d = S_FINAL;
            round_d = L_START_A;
          end
        end
      end

      S_AD: begin
        o_mux_select = 1'b1;
        if (round_q == L_START_B) begin
          o_data_ready            = 1'b1;
          o_enable_xor_data_begin = i_data_valid;
        end
        if ((round_q != L_START_B) || i_data_valid) begin
          o_enable_state_reg = 1'b1;
          round_d            = round_q + 4'd1;
          if (last_round) begin
            ad_cnt_d = ad_cnt_q - L_ONE;
            round_d  = L_START_B;
            if (ad_cnt_q == L_ONE) begin
              o_enable_xor_lsb_end = 1'b1;
              if (pt_cnt_q != '0) begin
                state_d = S_PT;
              end else begin
                state_d = S_FINAL;
                round_d = L_START_A;
              end
            end
          end
        end
      end

      S_PT: begin
        o_mux_select = 1'b1;
        if (round_q == L_START_B) begin
          o_data_ready            = 1'b1;
          o_enable_xor_data_begin = i_data_valid;
          o_enable_cipher_reg     = i_data_valid;
        end
        if ((round_q != L_START_B) || i_data_valid) begin
          o_enable_state_reg = 1'b1;
          round_d            = round_q + 4'd1;
          if (last_round) begin
            pt_cnt_d = pt_cnt_q - L_ONE;
            round_d  = L_START_B;
            if (pt_cnt_q == L_ONE) begin
              state_d = S_FINAL;
              round_d = L_START_A;
            end
          end
        end
      end

      S_FINAL: begin
        o_mux_select = 1'b1;
        if (round_q == L_START_A) begin
          o_data_ready            = 1'b1;
          o_enable_xor_data_begin = i_data_valid;
          o_enable_xor_key_begin  = i_data_valid;
          o_enable_cipher_reg     = i_data_valid;
        end
        if ((round_q != L_START_A) || i_data_valid) begin
          o_enable_state_reg = 1'b1;
          round_d            = round_q + 4'd1;
          if (last_round) begin
            o_enable_xor_key_end = 1'b1;
            o_enable_tag_reg     = 1'b1;
            tag_valid_d          = 1'b1;
            state_d              = S_IDLE;
            round_d              = 4'd0;
          end
        end
      end

      S_ABORT: begin
        state_d = S_IDLE;
        round_d = 4'd0;
      end

      default: begin
        state_d = S_IDLE;
        round_d = 4'd0;
      end
    endcase

    // Abort wins over any transition, capture or flag update decided above.
    if (abort_hit) begin
      state_d     = S_ABORT;
      round_d     = 4'd0;
      ad_cnt_d    = '0;
      pt_cnt_d    = '0;
      sys_en_d    = 1'b0;
      tag_valid_d = 1'b0;
    end

    cipher_valid_d = o_enable_cipher_reg && !abort_hit;
  end

endmodule

// File: tb/tb_ascon_controller.sv
// Self-checking bench for ascon_controller: expected per-round control
// signatures are generated from the phase/block rules and compared cycle
// by cycle, with random handshake stalls and directed corner cases.
module tb_ascon_controller;

  localparam int RA = 12;
  localparam int RB = 6;

  typedef struct packed {
    logic [3:0] rnd;
    logic       mux;
    logic       kb;
    logic       db;
    logic       ke;
    logic       lsb;
    logic       cr;
    logic       tr;
    logic       rdy;
  } sig_t;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       i_start = 1'b0;
  logic       i_abort = 1'b0;
  logic [3:0] i_ad_blocks = 4'd0;
  logic [3:0] i_pt_blocks = 4'd0;
  logic       i_data_valid = 1'b0;
  logic       o_data_ready, o_sys_enable, o_mux_select;
  logic       o_enable_xor_key_begin, o_enable_xor_data_begin;
  logic       o_enable_xor_key_end, o_enable_xor_lsb_end;
  logic       o_enable_cipher_reg, o_enable_tag_reg, o_enable_state_reg;
  logic [3:0] o_round;
  logic       o_cipher_valid, o_tag_valid, o_busy;

  int   n_tests = 0;
  int   n_fail  = 0;
  sig_t exp_q[$];

  ascon_controller dut (
    .clock                   (clock),
    .reset_n                 (reset_n),
    .i_start                 (i_start),
    .i_abort                 (i_abort),
    .i_ad_blocks             (i_ad_blocks),
    .i_pt_blocks             (i_pt_blocks),
    .i_data_valid            (i_data_valid),
    .o_data_ready            (o_data_ready),
    .o_sys_enable            (o_sys_enable),
    .o_mux_select            (o_mux_select),
    .o_enable_xor_key_begin  (o_enable_xor_key_begin),
    .o_enable_xor_data_begin (o_enable_xor_data_begin),
    .o_enable_xor_key_end    (o_enable_xor_key_end),
    .o_enable_xor_lsb_end    (o_enable_xor_lsb_end),
    .o_enable_cipher_reg     (o_enable_cipher_reg),
    .o_enable_tag_reg        (o_enable_tag_reg),
    .o_enable_state_reg      (o_enable_state_reg),
    .o_round                 (o_round),
    .o_cipher_valid          (o_cipher_valid),
    .o_tag_valid             (o_tag_valid),
    .o_busy                  (o_busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] all_outputs();
    logic [31:0] v;
    v = '0;
    v[16:0] = {o_data_ready, o_sys_enable, o_mux_select, o_enable_xor_key_begin,
               o_enable_xor_data_begin, o_enable_xor_key_end, o_enable_xor_lsb_end,
               o_enable_cipher_reg, o_enable_tag_reg, o_enable_state_reg, o_round,
               o_cipher_valid, o_tag_valid, o_busy};
    return v;
  endfunction

  function automatic sig_t observed_sig();
    sig_t s;
    s.rnd = o_round;
    s.mux = o_mux_select;
    s.kb  = o_enable_xor_key_begin;
    s.db  = o_enable_xor_data_begin;
    s.ke  = o_enable_xor_key_end;
    s.lsb = o_enable_xor_lsb_end;
    s.cr  = o_enable_cipher_reg;
    s.tr  = o_enable_tag_reg;
    s.rdy = o_data_ready;
    return s;
  endfunction

  // Reference model: list every executed round of the whole message.
  task automatic build_model(input int a, input int p_in);
    sig_t s;
    int   p;
    p = (p_in == 0) ? 1 : p_in;
    exp_q.delete();
    for (int r = 12 - RA; r < 12; r++) begin
      s = '0;
      s.rnd = 4'(r);
      s.mux = (r != 12 - RA);
      s.ke  = (r == 11);
      s.lsb = (r == 11) && (a == 0);
      exp_q.push_back(s);
    end
    for (int b = 0; b < a + p - 1; b++) begin
      for (int r = 12 - RB; r < 12; r++) begin
        s = '0;
        s.rnd = 4'(r);
        s.mux = 1'b1;
        s.rdy = (r == 12 - RB);
        s.db  = (r == 12 - RB);
        s.cr  = (r == 12 - RB) && (b >= a);
        s.lsb = (r == 11) && (b == a - 1);
        exp_q.push_back(s);
      end
    end
    for (int r = 12 - RA; r < 12; r++) begin
      s = '0;
      s.rnd = 4'(r);
      s.mux = 1'b1;
      s.rdy = (r == 12 - RA);
      s.db  = (r == 12 - RA);
      s.kb  = (r == 12 - RA);
      s.cr  = (r == 12 - RA);
      s.ke  = (r == 11);
      s.tr  = (r == 11);
      exp_q.push_back(s);
    end
  endtask

  // One full message; stall_hs/stall_len hold valid low at a chosen handshake,
  // rnd randomises valid every cycle, start_at pulses i_start mid-run.
  task automatic run_txn(input int a, input int p_in, input int stall_hs, input int stall_len,
                         input bit rnd, input int start_at);
    int   n_exp, cyc, hs, stalls, ins, pulses, stall_left, p;
    logic prev_cr, v;
    sig_t e;
    p = (p_in == 0) ? 1 : p_in;
    build_model(a, p_in);
    n_exp = exp_q.size();
    cyc = 0; hs = 0; stalls = 0; ins = 0; pulses = 0; prev_cr = 1'b0;
    stall_left = stall_len;

    @(posedge clock); #1;
    i_start = 1'b1;
    i_ad_blocks = 4'(a);
    i_pt_blocks = 4'(p_in);
    i_data_valid = 1'b0;
    @(negedge clock);
    check("idle_ready", 32'(o_data_ready), 0);
    @(posedge clock); #1;
    i_start = 1'b0;
    i_ad_blocks = 4'($urandom);
    i_pt_blocks = 4'($urandom);

    while (exp_q.size() > 0 && cyc < 400) begin
      i_start = (cyc == start_at);
      if (exp_q[0].rdy && hs == stall_hs && stall_left > 0) begin
        v = 1'b0;
        stall_left--;
      end else if (rnd) begin
        v = ($urandom_range(0, 2) != 0);
      end else begin
        v = 1'b1;
      end
      if (exp_q[0].rdy && !v) ins++;
      i_data_valid = v;
      @(negedge clock);
      if (cyc == 0) begin
        check("tag_clr_on_start", 32'(o_tag_valid), 0);
        check("sys_en_on_start", 32'(o_sys_enable), 1);
      end
      check("cipher_valid", 32'(o_cipher_valid), 32'(prev_cr));
      pulses += int'(o_cipher_valid);
      check("busy", 32'(o_busy), 1);
      if (o_enable_state_reg) begin
        e = exp_q.pop_front();
        check("round_sig", 32'(observed_sig()), 32'(e));
        if (e.rdy) hs++;
        prev_cr = o_enable_cipher_reg;
      end else begin
        check("stall", {26'd0, o_data_ready, i_data_valid, o_round},
              {26'd0, 1'b1, 1'b0, exp_q[0].rnd});
        stalls++;
        prev_cr = 1'b0;
      end
      cyc++;
      @(posedge clock); #1;
    end
    i_start = 1'b0;
    i_data_valid = 1'b0;
    check("timeout", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clock);
    check("cipher_valid_end", 32'(o_cipher_valid), 32'(prev_cr));
    pulses += int'(o_cipher_valid);
    check("done_busy", 32'(o_busy), 0);
    check("done_tag_valid", 32'(o_tag_valid), 1);
    check("done_sys_en", 32'(o_sys_enable), 1);
    check("done_ready", 32'(o_data_ready), 0);
    check("cycles", cyc, n_exp + ins);
    check("stall_count", stalls, ins);
    check("cipher_pulses", pulses, p);
  endtask

  task automatic abort_test();
    int found;
    found = 0;
    @(posedge clock); #1;
    i_start = 1'b1;
    i_ad_blocks = 4'd1;
    i_pt_blocks = 4'd1;
    i_data_valid = 1'b1;
    @(posedge clock); #1;
    i_start = 1'b0;
    for (int k = 0; k < 40 && found == 0; k++) begin
      @(negedge clock);
      if (o_enable_state_reg && o_round == 4'd5) found = 1;
      else begin
        @(posedge clock); #1;
      end
    end
    check("abort_round5_seen", found, 1);
    i_abort = 1'b1;
    @(posedge clock); #1;
    i_abort = 1'b0;
    @(negedge clock);
    check("abort_sys_en", 32'(o_sys_enable), 0);
    check("abort_busy", 32'(o_busy), 1);
    check("abort_state_reg", 32'(o_enable_state_reg), 0);
    check("abort_ready", 32'(o_data_ready), 0);
    @(posedge clock); #1;
    @(negedge clock);
    check("post_abort_busy", 32'(o_busy), 0);
    check("post_abort_tag", 32'(o_tag_valid), 0);
    check("post_abort_sys_en", 32'(o_sys_enable), 0);
    i_data_valid = 1'b0;
  endtask

  task automatic reset_mid_final();
    @(posedge clock); #1;
    i_start = 1'b1;
    i_ad_blocks = 4'd0;
    i_pt_blocks = 4'd1;
    i_data_valid = 1'b1;
    @(posedge clock); #1;
    i_start = 1'b0;
    repeat (18) @(posedge clock);
    #1;
    check("pre_reset_busy", 32'(o_busy), 1);
    reset_n = 1'b0;
    #1;
    check("reset_outputs", all_outputs(), 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    i_data_valid = 1'b0;
    @(negedge clock);
    check("after_reset_outputs", all_outputs(), 0);
  endtask

  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_outputs", all_outputs(), 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    i_abort = 1'b1;
    @(posedge clock); #1;
    i_abort = 1'b0;
    @(negedge clock);
    check("idle_abort_ignored", all_outputs(), 0);

    run_txn(0, 1, -1, 0, 1'b0, -1);
    run_txn(2, 3, -1, 0, 1'b0, -1);
    run_txn(1, 2, 1, 3, 1'b0, -1);
    abort_test();
    run_txn(1, 1, -1, 0, 1'b0, -1);
    run_txn(2, 2, -1, 0, 1'b0, 14);
    run_txn(0, 0, -1, 0, 1'b0, -1);
    reset_mid_final();
    run_txn(1, 1, -1, 0, 1'b0, -1);
    for (int t = 0; t < 10; t++) begin
      run_txn(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), -1, 0, 1'b1,
              int'($urandom_range(0, 30)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
